// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extension, writeback select,
// same-cycle register-file bypass and a retired-instruction counter.
module mem_wb_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          flush,
   input  logic          mem_valid,
   input  logic          mem_reg_write,
   input  logic          mem_to_reg,
   input  logic          mem_link,
   input  logic [AW-1:0] mem_rd,
   input  logic [DW-1:0] mem_alu_result,
   input  logic [DW-1:0] mem_load_data,
   input  logic [1:0]    mem_load_size,
   input  logic          mem_load_unsigned,
   input  logic [DW-1:0] mem_pc_plus4,
   input  logic [AW-1:0] id_read_reg1,
   input  logic [AW-1:0] id_read_reg2,
   input  logic [DW-1:0] rf_read_data1,
   input  logic [DW-1:0] rf_read_data2,
   output logic          wb_reg_write,
   output logic [AW-1:0] wb_write_reg,
   output logic [DW-1:0] wb_write_data,
   output logic [DW-1:0] fwd_data1,
   output logic [DW-1:0] fwd_data2,
   output logic [DW-1:0] retire_count
);

   logic          r_valid;
   logic          r_reg_write;
   logic          r_to_reg;
   logic          r_link;
   logic [AW-1:0] r_rd;
   logic [DW-1:0] r_alu;
   logic [DW-1:0] r_load_data;
   logic [1:0]    r_size;
   logic          r_unsigned;
   logic [DW-1:0] r_pc4;
   logic [DW-1:0] r_retire_count;

   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [DW-1:0] w_load;
   logic [DW-1:0] w_data;
   logic          w_we;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_to_reg    <= 1'b0;
         r_link      <= 1'b0;
         r_rd        <= '0;
         r_alu       <= '0;
         r_load_data <= '0;
         r_size      <= '0;
         r_unsigned  <= 1'b0;
         r_pc4       <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (!stall) begin
         r_valid     <= mem_valid;
         r_reg_write <= mem_reg_write;
         r_to_reg    <= mem_to_reg;
         r_link      <= mem_link;
         r_rd        <= mem_rd;
         r_alu       <= mem_alu_result;
         r_load_data <= mem_load_data;
         r_size      <= mem_load_size;
         r_unsigned  <= mem_load_unsigned;
         r_pc4       <= mem_pc_plus4;
      end
   end

   // The WB instruction retires when it leaves the stage (advance or flush).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_retire_count <= '0;
      else if (r_valid && (!stall || flush))
         r_retire_count <= r_retire_count + 1'b1;
   end

   always_comb begin
      w_byte = r_load_data[7:0];
      unique case (r_alu[1:0])
         2'd0: w_byte = r_load_data[7:0];
         2'd1: w_byte = r_load_data[15:8];
         2'd2: w_byte = r_load_data[23:16];
         2'd3: w_byte = r_load_data[31:24];
      endcase
      w_half = r_alu[1] ? r_load_data[31:16] : r_load_data[15:0];
      w_load = r_load_data;
      unique case (r_size)
         2'd0: w_load = {{24{~r_unsigned & w_byte[7]}}, w_byte};
         2'd1: w_load = {{16{~r_unsigned & w_half[15]}}, w_half};
         default: w_load = r_load_data;
      endcase
      w_data = r_alu;
      if (r_link)
         w_data = r_pc4;
      else if (r_to_reg)
         w_data = w_load;
   end

   assign w_we          = r_valid & r_reg_write & (r_rd != '0);
   assign wb_reg_write  = w_we;
   assign wb_write_reg  = r_rd;
   assign wb_write_data = w_data;
   assign retire_count  = r_retire_count;

   assign fwd_data1 = (w_we && r_rd == id_read_reg1) ? w_data : rf_read_data1;
   assign fwd_data2 = (w_we && r_rd == id_read_reg2) ? w_data : rf_read_data2;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
// Each task drives one scenario and checks the outputs inline.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush;
   logic        mem_valid, mem_reg_write, mem_to_reg, mem_link;
   logic [4:0]  mem_rd;
   logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4;
   logic [1:0]  mem_load_size;
   logic        mem_load_unsigned;
   logic [4:0]  id_read_reg1, id_read_reg2;
   logic [31:0] rf_read_data1, rf_read_data2;
   logic        wb_reg_write;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data, fwd_data1, fwd_data2, retire_count;

   int checks = 0;
   int errors = 0;
   logic        exp_valid;
   logic [31:0] exp_cnt;

   always #5 clk = ~clk;

   mem_wb_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
      .mem_to_reg(mem_to_reg), .mem_link(mem_link), .mem_rd(mem_rd),
      .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
      .mem_load_size(mem_load_size),
      .mem_load_unsigned(mem_load_unsigned),
      .mem_pc_plus4(mem_pc_plus4),
      .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2),
      .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
      .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
      .wb_write_data(wb_write_data), .fwd_data1(fwd_data1),
      .fwd_data2(fwd_data2), .retire_count(retire_count)
   );

   // Tracks WB occupancy so the expected retire count is known.
   task automatic step();
      @(posedge clk);
      if (exp_valid && (!stall || flush)) exp_cnt = exp_cnt + 1;
      if (flush) exp_valid = 1'b0;
      else if (!stall) exp_valid = mem_valid;
      #1;
   endtask

   task automatic drive(input logic v, input logic we, input logic tr,
                        input logic lk, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] ld,
                        input logic [1:0] sz, input logic us,
                        input logic [31:0] pc4);
      mem_valid = v; mem_reg_write = we; mem_to_reg = tr;
      mem_link = lk; mem_rd = rd; mem_alu_result = alu;
      mem_load_data = ld; mem_load_size = sz;
      mem_load_unsigned = us; mem_pc_plus4 = pc4;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; stall = 0; flush = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      id_read_reg1 = 0; id_read_reg2 = 0;
      rf_read_data1 = 0; rf_read_data2 = 0;
      exp_valid = 0; exp_cnt = 0;
      #12 rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (wb_reg_write !== 1'b0 || wb_write_reg !== 5'd0 ||
          wb_write_data !== 32'd0 || retire_count !== 32'd0) begin
         errors++;
         $display("FAIL reset: we=%b rd=%0d data=%h cnt=%h want 0",
                  wb_reg_write, wb_write_reg, wb_write_data, retire_count);
      end
   endtask

   task automatic test_alu_write();
      drive(1, 1, 0, 0, 5, 32'h1234, 0, 2, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (wb_reg_write !== 1'b1 || wb_write_reg !== 5'd5 ||
          wb_write_data !== 32'h0000_1234 || retire_count !== 32'd0) begin
         errors++;
         $display("FAIL alu_write: we=%b rd=%0d data=%h cnt=%0d want 1/5/00001234/0",
                  wb_reg_write, wb_write_reg, wb_write_data, retire_count);
      end
      step();
      checks++;
      if (retire_count !== 32'd1 || wb_reg_write !== 1'b0) begin
         errors++;
         $display("FAIL alu_retire: cnt=%0d we=%b want 1/0",
                  retire_count, wb_reg_write);
      end
   endtask

   task automatic test_load_extend();
      logic [1:0]  sz[6]   = '{0, 0, 1, 1, 0, 2};
      logic [31:0] ad[6]   = '{2, 0, 2, 0, 3, 1};
      logic        us[6]   = '{0, 0, 1, 0, 0, 0};
      logic [31:0] want[6] = '{32'hFFFF_FFFF, 32'h0000_0001,
                               32'h0000_80FF, 32'h0000_7F01,
                               32'hFFFF_FF80, 32'h80FF_7F01};
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 1, 0, 9, ad[i], 32'h80FF_7F01, sz[i], us[i], 0);
         step();
         checks++;
         if (wb_write_data !== want[i] || wb_reg_write !== 1'b1) begin
            errors++;
            $display("FAIL load_ext[%0d]: data=%h we=%b want %h/1",
                     i, wb_write_data, wb_reg_write, want[i]);
         end
      end
   endtask

   task automatic test_link();
      drive(1, 1, 1, 1, 31, 32'h5555, 32'h7777, 2, 0, 32'h0040_0010);
      step();
      checks++;
      if (wb_write_data !== 32'h0040_0010 || wb_reg_write !== 1'b1 ||
          wb_write_reg !== 5'd31) begin
         errors++;
         $display("FAIL link: data=%h we=%b rd=%0d want 00400010/1/31",
                  wb_write_data, wb_reg_write, wb_write_reg);
      end
      drive(1, 1, 1, 1, 0, 32'h5555, 32'h7777, 2, 0, 32'h0040_0010);
      id_read_reg1 = 0; rf_read_data1 = 32'hA5A5_0000;
      step();
      checks++;
      if (wb_reg_write !== 1'b0 || fwd_data1 !== 32'hA5A5_0000) begin
         errors++;
         $display("FAIL link_r0: we=%b fwd1=%h want 0/a5a50000",
                  wb_reg_write, fwd_data1);
      end
   endtask

   task automatic test_bypass();
      drive(1, 1, 0, 0, 7, 32'hDEAD_BEEF, 0, 2, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      id_read_reg1 = 7; rf_read_data1 = 32'h1;
      id_read_reg2 = 8; rf_read_data2 = 32'h2222_2222;
      #1;
      checks++;
      if (fwd_data1 !== 32'hDEAD_BEEF || fwd_data2 !== 32'h2222_2222) begin
         errors++;
         $display("FAIL bypass: fwd1=%h fwd2=%h want deadbeef/22222222",
                  fwd_data1, fwd_data2);
      end
      id_read_reg2 = 7;
      #1;
      checks++;
      if (fwd_data2 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL bypass2: fwd2=%h want deadbeef", fwd_data2);
      end
      id_read_reg2 = 8;
   endtask

   task automatic test_stall_flush();
      logic [31:0] c0;
      drive(1, 1, 0, 0, 12, 32'hCAFE_0001, 0, 2, 0, 0);
      step();
      c0 = exp_cnt;
      stall = 1;
      drive(1, 1, 0, 0, 13, 32'h0BAD_0BAD, 0, 2, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (wb_reg_write !== 1'b1 || wb_write_reg !== 5'd12 ||
             wb_write_data !== 32'hCAFE_0001 || retire_count !== c0) begin
            errors++;
            $display("FAIL stall[%0d]: we=%b rd=%0d data=%h cnt=%0d want 1/12/cafe0001/%0d",
                     i, wb_reg_write, wb_write_reg, wb_write_data,
                     retire_count, c0);
         end
      end
      stall = 0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step();
      checks++;
      if (retire_count !== c0 + 1 || retire_count !== exp_cnt) begin
         errors++;
         $display("FAIL stall_release: cnt=%0d want %0d",
                  retire_count, c0 + 1);
      end
      drive(1, 1, 0, 0, 14, 32'h1111, 0, 2, 0, 0);
      step();
      stall = 1; flush = 1;
      step();
      stall = 0; flush = 0;
      checks++;
      if (wb_reg_write !== 1'b0 || retire_count !== c0 + 2) begin
         errors++;
         $display("FAIL stall_flush: we=%b cnt=%0d want 0/%0d",
                  wb_reg_write, retire_count, c0 + 2);
      end
   endtask

   task automatic test_async_reset();
      drive(1, 1, 0, 0, 3, 32'h3333, 0, 2, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      stall = 1;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (wb_reg_write !== 1'b0 || retire_count !== 32'd0 ||
          wb_write_data !== 32'd0) begin
         errors++;
         $display("FAIL async_reset: we=%b cnt=%0d data=%h want 0/0/0",
                  wb_reg_write, retire_count, wb_write_data);
      end
      stall = 0;
      exp_valid = 0; exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.r_retire_count = 32'hFFFF_FFFF;
      #1 release dut.r_retire_count;
      exp_cnt = 32'hFFFF_FFFF;
      drive(1, 1, 0, 0, 4, 32'h4, 0, 2, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (retire_count !== 32'hFFFF_FFFF) begin
         errors++;
         $display("FAIL wrap_pre: cnt=%h want ffffffff", retire_count);
      end
      step();
      checks++;
      if (retire_count !== 32'd0 || retire_count !== exp_cnt) begin
         errors++;
         $display("FAIL wrap: cnt=%h want 00000000", retire_count);
      end
   endtask

   initial begin
      test_reset();
      test_alu_write();
      test_load_extend();
      test_link();
      test_bypass();
      test_stall_flush();
      test_async_reset();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 32-bit MIPS-style core.
- Captures MEM-stage results and extends load data.
- Selects the final write value and drives the RegisterFile write port (reg_write, write_reg, write_data).
- Bypasses same-cycle writes onto the ID-stage read data, covering the register file's old-value read during the write cycle, and counts retired instructions.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- AW, 5, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold the WB register contents
- flush  in  1  load a bubble into WB instead of the MEM inputs
- mem_valid  in  1  MEM stage holds a real instruction
- mem_reg_write  in  1  instruction writes rd
- mem_to_reg  in  1  write value is load data
- mem_link  in  1  write value is pc_plus4 (jal/jalr)
- mem_rd  in  5  destination register
- mem_alu_result  in  32  ALU result / load address
- mem_load_data  in  32  raw data memory word
- mem_load_size  in  2  0=byte, 1=half, 2=word, 3=word
- mem_load_unsigned  in  1  zero-extend instead of sign-extend
- mem_pc_plus4  in  32  link value
- id_read_reg1, id_read_reg2  in  5 each  ID-stage source indices
- rf_read_data1, rf_read_data2  in  32 each  RegisterFile read outputs
- wb_reg_write  out  1  to RegisterFile reg_write
- wb_write_reg  out  5  to RegisterFile write_reg
- wb_write_data  out  32  to RegisterFile write_data
- fwd_data1, fwd_data2  out  32 each  bypassed operands to ID
- retire_count  out  32  retired instruction counter

Behaviour:
- Reset (rst_n=0, async): wb_valid=0; all captured fields 0; retire_count=0. Consequently wb_reg_write=0, wb_write_reg=0, wb_write_data=0.
- Rising edge with rst_n=1: priority is flush > stall > capture.
  - flush: wb_valid<=0; the other captured fields are don't-care.
  - stall only: all fields hold.
  - Otherwise: all mem_* inputs are captured; wb_valid<=mem_valid.
- Latency: exactly 1 cycle from mem_* inputs to wb_* outputs. Outputs are purely from registered state.
- wb_reg_write = wb_valid & reg_write & (rd != 0). Writes to r0 are always suppressed.
- wb_write_reg = captured rd.
- Write-data select, priority order: link → pc_plus4; else to_reg → extended load; else alu_result.
- Load extension uses captured alu_result[1:0], little-endian:
  - Byte: lane addr[1:0] (00 selects [7:0], 11 selects [31:24]).
  - Half: lane addr[1] (0 selects [15:0], 1 selects [31:16]); addr[0] is ignored.
  - Sign- or zero-extend per the unsigned flag. Sizes 2 and 3 pass the full word unchanged.
- Bypass (combinational):
  - fwd_data1 = (wb_reg_write & wb_write_reg == id_read_reg1) ? wb_write_data : rf_read_data1.
  - fwd_data2 is the same using id_read_reg2 and rf_read_data2.
  - Index 0 never bypasses, because wb_reg_write is 0 for rd=0.
- Retire counter:
  - Increments by 1 on an edge where wb_valid=1 and (stall=0 or flush=1), i.e. the WB instruction leaves the stage.
  - A stalled instruction is counted once. The count wraps from 0xFFFFFFFF to 0.
- Stall with wb_reg_write=1 re-presents the same write every cycle. This is idempotent and intended.
- Reset asserted mid-stall or mid-flush clears the stage immediately, without waiting for a clock edge.
- Asserting stall and flush together: flush wins.

Test Plan:
- Reset then release; drive mem_valid=1, reg_write=1, rd=5, alu_result=0x1234, to_reg=0, link=0 → one cycle later wb_reg_write=1, wb_write_reg=5, wb_write_data=0x00001234; retire_count=1 after the next edge.
- Load of word 0x80FF7F01:
  - size=0, addr=0x2, signed → wb_write_data=0xFFFFFFFF.
  - addr=0x0, signed → 0x00000001.
  - size=1, addr=0x2, unsigned → 0x000080FF.
  - size=1, addr=0x0, signed → 0x00007F01.
- link=1, pc_plus4=0x00400010, rd=31 → wb_write_data=0x00400010. Same instruction with rd=0 → wb_reg_write=0.
- WB writing rd=7 value 0xDEADBEEF, id_read_reg1=7, rf_read_data1=0x1 → fwd_data1=0xDEADBEEF. id_read_reg2=8 → fwd_data2=rf_read_data2.
- Stall for 3 cycles with a valid WB instruction → outputs constant and retire_count advances by exactly 1 after release. flush=1 together with stall=1 → wb_valid=0 next cycle.
- Assert rst_n=0 between clock edges while wb_reg_write=1 → wb_reg_write drops immediately, retire_count=0. Separately, preload the counter to 0xFFFFFFFF and retire one instruction → counter reads 0.
